// File: rtl/scr1_scu_multi_if.sv
// ============================================================================
// Module      : scr1_scu_multi_if
// Description : TAP-synchronised DR channel between the TAP sync block
//               (master) and the multi-domain system control unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scr1_scu_multi_if;
  logic tapc_ch_sel_i;
  logic tapc_ch_id_i;
  logic tapc_ch_capture_i;
  logic tapc_ch_shift_i;
  logic tapc_ch_update_i;
  logic tapc_ch_tdi_i;
  logic tapc_ch_tdo_o;

  modport master (
    output tapc_ch_sel_i, tapc_ch_id_i, tapc_ch_capture_i,
           tapc_ch_shift_i, tapc_ch_update_i, tapc_ch_tdi_i,
    input  tapc_ch_tdo_o
  );

  modport slave (
    input  tapc_ch_sel_i, tapc_ch_id_i, tapc_ch_capture_i,
           tapc_ch_shift_i, tapc_ch_update_i, tapc_ch_tdi_i,
    output tapc_ch_tdo_o
  );
endinterface

`default_nettype wire

// File: rtl/scr1_scu_multi.sv
// ============================================================================
// Module      : scr1_scu_multi
// Description : System control unit producing NUM_DOM ordered reset domains.
//               CSRs are reached through a TAP-synchronised DR channel; the
//               reset tree cascades release in order, supports self-timed
//               reset pulses and per-domain isolation from the cascade.
//               Optional macro SCR1_SCU_MULTI_CFG_LOCK_EN adds a LOCK CSR at
//               address 7 that freezes CONTROL, MODE and PULSE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_scu_multi #(
  parameter int NUM_DOM      = 4,
  parameter int ADDR_W       = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  scr1_scu_multi_if.slave      tap,
  input  logic [NUM_DOM-1:0]   ext_rst_req_i,
  output logic [NUM_DOM-1:0]   dom_rst_n_o,
  output logic [NUM_DOM-1:0]   dom_rst_status_o,
  output logic [NUM_DOM-1:0]   dom_rdc_qlfy_o
);

  localparam int c_DR_W  = 2 + ADDR_W + NUM_DOM;
  localparam int c_CNT_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [1:0] c_OP_WRITE = 2'd0;
  localparam logic [1:0] c_OP_READ  = 2'd1;
  localparam logic [1:0] c_OP_SET   = 2'd2;
  localparam logic [1:0] c_OP_CLEAR = 2'd3;

  localparam logic [ADDR_W-1:0] c_ADDR_CONTROL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_ADDR_MODE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_STATUS  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_ADDR_STICKY  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_ADDR_PULSE   = ADDR_W'(4);
`ifdef SCR1_SCU_MULTI_CFG_LOCK_EN
  localparam logic [ADDR_W-1:0] c_ADDR_LOCK    = ADDR_W'(7);
`endif

  logic [c_DR_W-1:0]   r_shift;
  logic [c_DR_W-1:0]   r_shadow;
  logic [NUM_DOM-1:0]  r_ctrl;
  logic [NUM_DOM-1:0]  r_mode;
  logic [NUM_DOM-1:0]  r_sticky;
  logic [NUM_DOM-1:0]  r_stat_prev;
  logic [NUM_DOM-1:0]  r_dom_rst_n;
  logic [NUM_DOM-1:0]  r_qlfy;
  logic [NUM_DOM-1:0]  r_sync [SYNC_STAGES];
  logic [c_CNT_W-1:0]  r_cnt  [NUM_DOM];

  logic                w_req;
  logic                w_upd;
  logic [1:0]          w_op;
  logic [ADDR_W-1:0]   w_addr;
  logic [NUM_DOM-1:0]  w_data;
  logic [NUM_DOM-1:0]  w_rdata;
  logic [NUM_DOM-1:0]  w_wdata;
  logic                w_wr_op;
  logic                w_setwr_op;
  logic                w_locked;
  logic [NUM_DOM-1:0]  w_status;
  logic [NUM_DOM-1:0]  w_rise;
  logic [NUM_DOM-1:0]  w_cnt_active;
  logic [NUM_DOM-1:0]  w_pulse_load;
  logic [NUM_DOM-1:0]  w_casc;
  logic [NUM_DOM-1:0]  w_dom_req;

  assign w_req      = tap.tapc_ch_sel_i & ~tap.tapc_ch_id_i;
  assign w_upd      = tap.tapc_ch_update_i & w_req;
  assign w_op       = r_shift[1:0];
  assign w_addr     = r_shift[ADDR_W+1:2];
  assign w_data     = r_shift[c_DR_W-1 -: NUM_DOM];
  assign w_wr_op    = (w_op != c_OP_READ);
  assign w_setwr_op = (w_op == c_OP_WRITE) | (w_op == c_OP_SET);
  assign w_status   = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_status & ~r_stat_prev;

  assign tap.tapc_ch_tdo_o = r_shift[0];
  assign dom_rst_n_o       = r_dom_rst_n;
  assign dom_rst_status_o  = w_status;
  assign dom_rdc_qlfy_o    = r_qlfy;

`ifdef SCR1_SCU_MULTI_CFG_LOCK_EN
  logic r_lock;

  // LOCK bit: set-only from the channel, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (w_upd && w_setwr_op && (w_addr == c_ADDR_LOCK) && w_data[0]) begin
      r_lock <= 1'b1;
    end
  end

  assign w_locked = r_lock;
`else
  assign w_locked = 1'b0;
`endif

  // CSR read mux; unmapped addresses read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      c_ADDR_CONTROL: w_rdata = r_ctrl;
      c_ADDR_MODE:    w_rdata = r_mode;
      c_ADDR_STATUS:  w_rdata = w_status;
      c_ADDR_STICKY:  w_rdata = r_sticky;
      c_ADDR_PULSE:   w_rdata = w_cnt_active;
`ifdef SCR1_SCU_MULTI_CFG_LOCK_EN
      c_ADDR_LOCK:    w_rdata = NUM_DOM'(r_lock);
`endif
      default:        w_rdata = '0;
    endcase
  end

  // Resulting write data of the requested op; also what the shadow returns.
  always_comb begin
    w_wdata = w_data;
    case (w_op)
      c_OP_WRITE: w_wdata = w_data;
      c_OP_READ:  w_wdata = w_rdata;
      c_OP_SET:   w_wdata = w_rdata | w_data;
      c_OP_CLEAR: w_wdata = w_rdata & ~w_data;
      default:    w_wdata = w_data;
    endcase
  end

  // DR shift register and shadow; capture wins over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_shadow <= '0;
    end else begin
      if (w_req && tap.tapc_ch_capture_i) begin
        r_shift <= r_shadow;
      end else if (w_req && tap.tapc_ch_shift_i) begin
        r_shift <= {tap.tapc_ch_tdi_i, r_shift[c_DR_W-1:1]};
      end
      if (w_upd) begin
        r_shadow <= {w_wdata, w_addr, w_op};
      end
    end
  end

  // CONTROL, MODE and STICKY registers; a coincident rising edge beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl      <= '0;
      r_mode      <= '0;
      r_sticky    <= '0;
      r_stat_prev <= '1;
    end else begin
      if (w_upd && w_wr_op && !w_locked && (w_addr == c_ADDR_CONTROL)) begin
        r_ctrl <= w_wdata;
      end
      if (w_upd && w_wr_op && !w_locked && (w_addr == c_ADDR_MODE)) begin
        r_mode <= w_wdata;
      end
      if (w_upd && (w_op == c_OP_CLEAR) && (w_addr == c_ADDR_STICKY)) begin
        r_sticky <= (r_sticky & ~w_data) | w_rise;
      end else begin
        r_sticky <= r_sticky | w_rise;
      end
      r_stat_prev <= w_status;
    end
  end

  assign w_pulse_load = (w_upd && w_setwr_op && !w_locked && (w_addr == c_ADDR_PULSE))
                        ? w_data : '0;

  // Per-domain pulse counters: load (or reload) on request, count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOM; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        if (w_pulse_load[i]) begin
          r_cnt[i] <= c_CNT_W'(PULSE_CYCLES);
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
        end
      end
    end
  end

  // Reset request per domain: all sources ORed, cascade from predecessor.
  always_comb begin
    w_casc       = '0;
    w_cnt_active = '0;
    for (int i = 0; i < NUM_DOM; i++) w_cnt_active[i] = (r_cnt[i] != '0);
    for (int i = 1; i < NUM_DOM; i++) w_casc[i] = ~r_mode[i] & w_status[i-1];
    w_dom_req = ext_rst_req_i | r_ctrl | w_cnt_active | w_casc;
  end

  // Registered domain resets, RDC qualifier and status synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dom_rst_n <= '0;
      r_qlfy      <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
    end else begin
      r_dom_rst_n <= ~w_dom_req;
      r_qlfy      <= r_dom_rst_n;
      r_sync[0]   <= ~r_dom_rst_n;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

endmodule

`default_nettype wire
